kpyd_scan_debounce: RTL

//  Upstream stage for the keypad-to-SSD path. Drives the 4x4 keypad column strobes and synchronizes
//  the active-low row inputs. Resolves one key per full scan frame and debounces it over several frames.

---
 rtl/kpyd_pkg.sv | 18 +
 rtl/kpyd_col_scan.sv | 55 +++++
 rtl/kpyd_scan_debounce.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/kpyd_pkg.sv
// Shared types and constants for the keypad scan/debounce path.
package kpyd_pkg;

  typedef enum logic {
    IDLE,
    HELD
  } kpyd_state_e;

  typedef logic [7:0] kpyd_code_t;

  localparam kpyd_code_t KPYD_NONE = 8'h00;

  // True when exactly one bit of a 4-bit vector is set.
  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
  endfunction

endpackage

// File: rtl/kpyd_col_scan.sv
// Column strobe generator: dwell counter plus active-low one-hot column ring.
module kpyd_col_scan
  import kpyd_pkg::*;
#(
  parameter int div_p = 12000
) (
  input  logic       clk_i,
  input  logic       reset_i,
  output logic [3:0] kpyd_col_o,
  output logic [1:0] col_idx_o,
  output logic       sample_o,
  output logic       frame_end_o
);

  localparam int CNT_W = (div_p > 1) ? $clog2(div_p) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(div_p - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       col_q, col_d;
  logic [1:0]       idx_q, idx_d;
  logic             last_dwell;

  assign last_dwell = (cnt_q == CNT_LAST);

  // NOTE: every signal driven here gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    col_d = col_q;
    idx_d = idx_q;
    if (last_dwell) begin
      cnt_d = '0;
      col_d = {col_q[2:0], col_q[3]};
      idx_d = idx_q + 2'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q <= '0;
      col_q <= 4'b1110;
      idx_q <= 2'd0;
    end else begin
      cnt_q <= cnt_d;
      col_q <= col_d;
      idx_q <= idx_d;
    end
  end

  assign kpyd_col_o  = col_q;
  assign col_idx_o   = idx_q;
  assign sample_o    = last_dwell;
  assign frame_end_o = last_dwell && (idx_q == 2'd3);

endmodule

// File: rtl/kpyd_scan_debounce.sv
// Keypad scanner front end: row synchronizer, per-frame key resolution and
// multi-frame debounce producing a one-hot {row,col} code.
module kpyd_scan_debounce
  import kpyd_pkg::*;
#(
  parameter int div_p      = 12000,
  parameter int debounce_p = 8
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [3:0] kpyd_row_i,
  output logic [3:0] kpyd_col_o,
  output logic [7:0] kpyd_o,
  output logic       valid_o,
  output logic       press_o
);

  localparam int STB_W = $clog2(debounce_p + 1);
  localparam logic [STB_W-1:0] STB_MAX = STB_W'(debounce_p);

  logic [1:0] col_idx;
  logic       sample;
  logic       frame_end;

  kpyd_col_scan #(
    .div_p(div_p)
  ) u_col_scan (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .kpyd_col_o (kpyd_col_o),
    .col_idx_o  (col_idx),
    .sample_o   (sample),
    .frame_end_o(frame_end)
  );

  // Rows are asynchronous to clk_i; two flops before anything decodes them.
  logic [3:0] row_meta_q, row_sync_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      row_meta_q <= 4'b1111;
      row_sync_q <= 4'b1111;
    end else begin
      row_meta_q <= kpyd_row_i;
      row_sync_q <= row_meta_q;
    end
  end

  logic [3:0] row_low;
  logic [3:0] col_oh;
  logic       col_hit;
  kpyd_code_t col_code;

  assign row_low  = ~row_sync_q;
  assign col_oh   = 4'b0001 << col_idx;
  assign col_hit  = sample && is_onehot4(row_low);
  assign col_code = {row_low, col_oh};

  // Hit count saturates at 2: anything beyond one hit is already a ghost/multi-key frame.
  logic [1:0] hit_cnt_q, hit_cnt_d;
  kpyd_code_t hit_code_q, hit_code_d;
  kpyd_code_t cand;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    hit_code_d = hit_code_q;
    if (col_hit) begin
      hit_code_d = col_code;
      hit_cnt_d  = (hit_cnt_q == 2'd0) ? 2'd1 : 2'd2;
    end
    cand = (hit_cnt_d == 2'd1) ? hit_code_d : KPYD_NONE;
    if (frame_end) begin
      hit_cnt_d  = 2'd0;
      hit_code_d = KPYD_NONE;
    end
  end

  logic [STB_W-1:0] stable_cnt_q, stable_cnt_d;
  kpyd_code_t       prev_q, prev_d;
  kpyd_code_t       kpyd_q, kpyd_d;
  kpyd_state_e      state_q, state_d;
  logic             press_q, press_d;
  logic             commit;

  always_comb begin
    stable_cnt_d = stable_cnt_q;
    prev_d       = prev_q;
    commit       = 1'b0;
    if (frame_end) begin
      if (cand == prev_q) begin
        if (stable_cnt_q != STB_MAX) stable_cnt_d = stable_cnt_q + STB_W'(1);
      end else begin
        stable_cnt_d = STB_W'(1);
        prev_d       = cand;
      end
      commit = (stable_cnt_d == STB_MAX) && (cand != kpyd_q);
    end
  end

  always_comb begin
    state_d = state_q;
    kpyd_d  = kpyd_q;
    press_d = 1'b0;
    if (commit) begin
      kpyd_d = cand;
      unique case (state_q)
        IDLE: begin
          if (cand != KPYD_NONE) begin
            state_d = HELD;
            press_d = 1'b1;
          end
        end
        HELD: begin
          if (cand == KPYD_NONE) begin
            state_d = IDLE;
          end else begin
            press_d = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      hit_cnt_q    <= 2'd0;
      hit_code_q   <= KPYD_NONE;
      stable_cnt_q <= '0;
      prev_q       <= KPYD_NONE;
      kpyd_q       <= KPYD_NONE;
      state_q      <= IDLE;
      press_q      <= 1'b0;
    end else begin
      hit_cnt_q    <= hit_cnt_d;
      hit_code_q   <= hit_code_d;
      stable_cnt_q <= stable_cnt_d;
      prev_q       <= prev_d;
      kpyd_q       <= kpyd_d;
      state_q      <= state_d;
      press_q      <= press_d;
    end
  end

  assign kpyd_o  = kpyd_q;
  assign valid_o = (state_q == HELD);
  assign press_o = press_q;

endmodule
